// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the programmable code lock.
package code_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROG    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  // Bits needed to hold the values 0..n; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/code_lock_timer.sv
// Saturating load/enable down-counter; o_done marks the enabled clock on which
// the count expires. A LIMIT of 0 keeps o_done permanently low.
module code_lock_timer
  import code_lock_pkg::*;
#(
  parameter int LIMIT = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);

  localparam int W = cnt_w(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = W'(LIMIT);
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (LIMIT != 0) && i_en && (cnt_q == W'(1));

endmodule

// File: rtl/code_lock_prog.sv
// Programmable code lock: whole-word code entry, fail counting with timed
// lockout, in-place reprogramming while open, optional digit gap and relock timers.
module code_lock_prog
  import code_lock_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {4'd2, 4'd3, 4'd2, 4'd7},
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int GAP_CYC     = 0,
  parameter int OPEN_CYC    = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DIGIT_W-1:0]            i_code,
  input  logic                          i_code_vld,
  input  logic                          i_close,
  input  logic                          i_prog,
  output logic                          o_open,
  output logic                          o_fail,
  output logic                          o_lockout,
  output logic                          o_prog_done,
  output logic [$clog2(MAX_FAIL+1)-1:0] o_fail_cnt,
  output logic [2:0]                    o_dbg_state
);

  localparam int CW     = CODE_LEN * DIGIT_W;
  localparam int IDX_W  = cnt_w(CODE_LEN);
  localparam int FCNT_W = $clog2(MAX_FAIL + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CW-1:0]       buf_q, buf_d;
  logic [CW-1:0]       shadow_q, shadow_d;
  logic [CW-1:0]       code_q, code_d;
  logic [FCNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic                fail_q, fail_d;
  logic                prog_done_q, prog_done_d;
  logic [CW+DIGIT_W-1:0] buf_shift, shadow_shift;
  logic                last_digit;
  logic gap_load, gap_en, gap_done;
  logic open_load, open_en, open_done;
  logic lock_load, lock_en, lock_done;

  // Newest digit enters the LS field, so the first digit ends up in the MS field.
  assign buf_shift    = {buf_q, i_code};
  assign shadow_shift = {shadow_q, i_code};
  assign last_digit   = (idx_q == IDX_W'(CODE_LEN - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    shadow_d    = shadow_q;
    code_d      = code_q;
    fail_cnt_d  = fail_cnt_q;
    fail_d      = 1'b0;
    prog_done_d = 1'b0;
    gap_load    = 1'b0;
    gap_en      = 1'b0;
    open_load   = 1'b0;
    open_en     = 1'b0;
    lock_load   = 1'b0;
    lock_en     = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (i_code_vld) begin
          buf_d    = buf_shift[CW-1:0];
          gap_load = 1'b1;
          if (last_digit) begin
            idx_d   = '0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (idx_q != '0) begin
          gap_en = 1'b1;
          if (gap_done) idx_d = '0;
        end
      end
      ST_CHECK: begin
        if (buf_q == code_q) begin
          state_d    = ST_OPEN;
          fail_cnt_d = '0;
          open_load  = 1'b1;
        end else begin
          fail_d = 1'b1;
          if (fail_cnt_q == FCNT_W'(MAX_FAIL - 1)) begin
            fail_cnt_d = FCNT_W'(MAX_FAIL);
            state_d    = ST_LOCKOUT;
            lock_load  = 1'b1;
          end else begin
            fail_cnt_d = fail_cnt_q + 1'b1;
            state_d    = ST_ENTRY;
          end
        end
      end
      ST_OPEN: begin
        open_en = 1'b1;
        if (i_close) begin
          state_d = ST_ENTRY;
        end else if (i_prog) begin
          idx_d   = '0;
          state_d = ST_PROG;
        end else if (open_done) begin
          state_d = ST_ENTRY;
        end
      end
      ST_PROG: begin
        if (i_close) begin
          idx_d   = '0;
          state_d = ST_ENTRY;
        end else if (i_code_vld) begin
          shadow_d = shadow_shift[CW-1:0];
          gap_load = 1'b1;
          if (last_digit) begin
            code_d      = shadow_shift[CW-1:0];
            prog_done_d = 1'b1;
            idx_d       = '0;
            open_load   = 1'b1;
            state_d     = ST_OPEN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (idx_q != '0) begin
          gap_en = 1'b1;
          if (gap_done) begin
            idx_d     = '0;
            open_load = 1'b1;
            state_d   = ST_OPEN;
          end
        end
      end
      ST_LOCKOUT: begin
        lock_en = 1'b1;
        if (lock_done) begin
          fail_cnt_d = '0;
          state_d    = ST_ENTRY;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_ENTRY;
      idx_q       <= '0;
      buf_q       <= '0;
      shadow_q    <= '0;
      code_q      <= DEFAULT_CODE;
      fail_cnt_q  <= '0;
      fail_q      <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      shadow_q    <= shadow_d;
      code_q      <= code_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_q      <= fail_d;
      prog_done_q <= prog_done_d;
    end
  end

  code_lock_timer #(.LIMIT(GAP_CYC)) u_gap_tmr (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(gap_load), .i_en(gap_en), .o_done(gap_done)
  );

  code_lock_timer #(.LIMIT(OPEN_CYC)) u_open_tmr (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(open_load), .i_en(open_en), .o_done(open_done)
  );

  code_lock_timer #(.LIMIT(LOCKOUT_CYC)) u_lock_tmr (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(lock_load), .i_en(lock_en), .o_done(lock_done)
  );

  assign o_open      = (state_q == ST_OPEN) || (state_q == ST_PROG);
  assign o_lockout   = (state_q == ST_LOCKOUT);
  assign o_fail      = fail_q;
  assign o_prog_done = prog_done_q;
  assign o_fail_cnt  = fail_cnt_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_code_lock_prog.sv
// Two lock instances (default and timed variants) driven in lockstep; output
// change events are checked against a digit-list reference model.
module tb_code_lock_prog;

  localparam int LEN = 4;
  localparam int EW  = 38;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code = '0;
  logic       vld = 1'b0;
  logic       close = 1'b0;
  logic       prog = 1'b0;

  logic       open_a, fail_a, lock_a, pd_a;
  logic [1:0] fcnt_a;
  logic [2:0] st_a;
  logic       open_b, fail_b, lock_b, pd_b;
  logic [1:0] fcnt_b;
  logic [2:0] st_b;

  code_lock_prog u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_code_vld(vld), .i_close(close),
    .i_prog(prog), .o_open(open_a), .o_fail(fail_a), .o_lockout(lock_a),
    .o_prog_done(pd_a), .o_fail_cnt(fcnt_a), .o_dbg_state(st_a)
  );

  code_lock_prog #(
    .MAX_FAIL(2), .LOCKOUT_CYC(20), .GAP_CYC(4), .OPEN_CYC(10)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_code_vld(vld), .i_close(close),
    .i_prog(prog), .o_open(open_b), .o_fail(fail_b), .o_lockout(lock_b),
    .o_prog_done(pd_b), .o_fail_cnt(fcnt_b), .o_dbg_state(st_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_PROG = 3, M_LOCK = 4;
  int def_code[LEN] = '{2, 3, 2, 7};
  int gp[2] = '{0, 4};
  int op[2] = '{0, 10};
  int lp[2] = '{1000, 20};
  int mf[2] = '{3, 2};
  int mode[2] = '{0, 0};
  int ent[2][LEN];
  int ent_n[2] = '{0, 0};
  int sh[2][LEN];
  int sh_n[2] = '{0, 0};
  int code_r[2][LEN];
  int idle_c[2] = '{0, 0};
  int fails[2] = '{0, 0};
  int el[2] = '{0, 0};
  logic m_fail[2] = '{1'b0, 1'b0};
  logic m_pd[2] = '{1'b0, 1'b0};
  logic [5:0] m_prev[2] = '{6'd0, 6'd0};
  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];

  function automatic logic [5:0] m_out(input int k);
    logic o;
    o = (mode[k] == M_OPEN) || (mode[k] == M_PROG);
    return {o, m_fail[k], (mode[k] == M_LOCK), m_pd[k], 2'(fails[k])};
  endfunction

  task automatic model_step(input int k);
    bit match;
    m_fail[k] = 1'b0;
    m_pd[k] = 1'b0;
    if (rst) begin
      mode[k] = M_ENTRY; ent_n[k] = 0; sh_n[k] = 0; idle_c[k] = 0;
      fails[k] = 0; el[k] = 0;
      for (int i = 0; i < LEN; i++) code_r[k][i] = def_code[i];
    end else begin
      case (mode[k])
        M_ENTRY: begin
          if (vld) begin
            ent[k][ent_n[k]] = int'(code);
            ent_n[k]++;
            idle_c[k] = 0;
            if (ent_n[k] == LEN) mode[k] = M_CHECK;
          end else if (ent_n[k] > 0 && gp[k] > 0) begin
            idle_c[k]++;
            if (idle_c[k] == gp[k]) begin ent_n[k] = 0; idle_c[k] = 0; end
          end
        end
        M_CHECK: begin
          match = 1'b1;
          for (int i = 0; i < LEN; i++) if (ent[k][i] != code_r[k][i]) match = 1'b0;
          ent_n[k] = 0;
          if (match) begin
            mode[k] = M_OPEN; fails[k] = 0; el[k] = 0;
          end else begin
            m_fail[k] = 1'b1;
            fails[k]++;
            if (fails[k] == mf[k]) begin mode[k] = M_LOCK; el[k] = 0; end
            else mode[k] = M_ENTRY;
          end
        end
        M_OPEN: begin
          if (close) mode[k] = M_ENTRY;
          else if (prog) begin mode[k] = M_PROG; sh_n[k] = 0; idle_c[k] = 0; end
          else if (op[k] > 0) begin
            el[k]++;
            if (el[k] == op[k]) mode[k] = M_ENTRY;
          end
        end
        M_PROG: begin
          if (close) mode[k] = M_ENTRY;
          else if (vld) begin
            sh[k][sh_n[k]] = int'(code);
            sh_n[k]++;
            idle_c[k] = 0;
            if (sh_n[k] == LEN) begin
              for (int i = 0; i < LEN; i++) code_r[k][i] = sh[k][i];
              m_pd[k] = 1'b1; mode[k] = M_OPEN; el[k] = 0;
            end
          end else if (sh_n[k] > 0 && gp[k] > 0) begin
            idle_c[k]++;
            if (idle_c[k] == gp[k]) begin mode[k] = M_OPEN; el[k] = 0; end
          end
        end
        default: begin
          el[k]++;
          if (el[k] == lp[k]) begin mode[k] = M_ENTRY; fails[k] = 0; end
        end
      endcase
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < LEN; i++) code_r[k][i] = def_code[i];
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
        model_step(k);
        if (m_out(k) != m_prev[k]) begin
          if (k == 0) exp_q_a.push_back({32'(cyc), m_out(k)});
          else        exp_q_b.push_back({32'(cyc), m_out(k)});
          m_prev[k] = m_out(k);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [5:0] dv[2];
  logic [5:0] d_prev[2] = '{6'd0, 6'd0};
  assign dv[0] = {open_a, fail_a, lock_a, pd_a, fcnt_a};
  assign dv[1] = {open_b, fail_b, lock_b, pd_b, fcnt_b};

  initial begin
    logic [EW-1:0] e;
    bit have;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (dv[k] !== d_prev[k]) begin
          have = (k == 0) ? (exp_q_a.size() > 0) : (exp_q_b.size() > 0);
          checks++;
          if (!have) begin
            failures++;
            $display("FAIL ev_extra dut%0d cyc=%0d got=%b prev=%b", k, cyc, dv[k], d_prev[k]);
          end else begin
            e = (k == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
            if (e[5:0] !== dv[k] || e[EW-1:6] != 32'(cyc)) begin
              failures++;
              $display("FAIL ev_dut%0d got=%b@%0d exp=%b@%0d", k, dv[k], cyc, e[5:0], e[EW-1:6]);
            end
          end
          d_prev[k] = dv[k];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic digit(input int d);
    vld = 1'b1; code = 4'(d);
    idle(1);
    vld = 1'b0;
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    digit(a); digit(b); digit(c); digit(d);
  endtask

  task automatic pulse(input bit c, input bit p);
    close = c; prog = p;
    idle(1);
    close = 1'b0; prog = 1'b0;
  endtask

  task automatic check_zero(input string name);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dv[k] !== 6'd0) begin
        failures++;
        $display("FAIL %s dut%0d got=%b exp=000000", name, k, dv[k]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_zero("reset_outs");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int act;
    idle(1);
    do_reset();
    // correct code, then close
    code4(2, 3, 2, 7); idle(3); pulse(1, 0); idle(3);
    // three wrong codes, digits during lockout, then correct code
    do_reset();
    for (int i = 0; i < 3; i++) begin code4(2, 3, 2, 8); idle(3); end
    code4(2, 3, 2, 7); idle(1010);
    code4(2, 3, 2, 7); idle(3); pulse(1, 0); idle(2);
    // reprogram to 5519
    do_reset();
    code4(2, 3, 2, 7); idle(2); pulse(0, 1); code4(5, 5, 1, 9); idle(2);
    pulse(1, 0); idle(2); code4(2, 3, 2, 7); idle(3); code4(5, 5, 1, 9); idle(3);
    pulse(1, 0); idle(2);
    // close and prog together, then auto-relock
    do_reset();
    code4(2, 3, 2, 7); idle(2); pulse(1, 1); idle(3);
    code4(2, 3, 2, 7); idle(15); pulse(1, 0); idle(2);
    // reset in the middle of programming
    do_reset();
    code4(2, 3, 2, 7); idle(2); pulse(0, 1); digit(5); digit(5);
    do_reset();
    code4(5, 5, 1, 9); idle(3); code4(2, 3, 2, 7); idle(3); pulse(1, 0); idle(2);
    // inter-digit gap
    do_reset();
    digit(2); digit(3); idle(4);
    digit(2); digit(7); digit(2); digit(3); digit(2); digit(7);
    idle(10); code4(2, 3, 2, 7); idle(3); pulse(1, 0); idle(2);
    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      act = $urandom_range(0, 19);
      if (act < 6) code4(2, 3, 2, 7);
      else if (act < 10) begin
        for (int j = 0; j < LEN; j++) begin
          digit($urandom_range(0, 15));
          idle($urandom_range(0, 5));
        end
      end else if (act < 12) pulse(1, 0);
      else if (act < 15) begin
        pulse($urandom_range(0, 7) == 0, 1);
        for (int j = 0; j < LEN; j++) begin
          digit(($urandom_range(0, 1) == 0) ? def_code[j] : $urandom_range(0, 15));
          if ($urandom_range(0, 5) == 0) pulse(1, 0);
          idle($urandom_range(0, 5));
        end
      end else if (act < 19) idle($urandom_range(0, 12));
      else begin rst = 1'b1; idle(1); rst = 1'b0; end
    end
    idle(20);
    checks++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      failures++;
      $display("FAIL ev_missing pending_a=%0d pending_b=%0d exp=0", exp_q_a.size(), exp_q_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
